pid_incr_ctrl: RTL and testbench
================================

# pid_incr_ctrl

Parametrised incremental (velocity-form) PID controller: u[n] = u[n-1] + K0·e[n] + K1·e[n-1] + K2·e[n-2], with e = setpoint − measurement. It generalises the fixed 16-bit, fixed-gain controller with:
- configurable width and fixed-point gains;
- a valid/ready sample handshake;
- a time-shared multiply-accumulate;
- output clamping with anti-windup;
- bumpless manual mode.

It sits between the sensor sample interface and the actuator command register.

## Interface
- WIDTH, 16: signed data width of setpoint, measurement, gains, output.
- FRAC, 0: fractional bits of gains; products are arithmetically shifted right by FRAC.
- OUT_MIN, −2^(WIDTH−1): lower output clamp. Must be ≤ 0.
- OUT_MAX, 2^(WIDTH−1)−1: upper output clamp. Must be ≥ 0.

- clk, input, 1: single clock, rising edge.
- reset, input, 1: synchronous, active-high.
- in_valid, input, 1: sample offered.
- in_ready, output, 1: controller can accept a sample.
- setpoint, input, WIDTH: signed target.
- meas, input, WIDTH: signed measurement.
- k0, k1, k2, input, WIDTH each: signed gains (Kp+Ki+Kd, −Kp−2Kd, Kd), latched at accept.
- man_en, input, 1: manual mode, latched at accept.
- man_value, input, WIDTH: manual command, latched at accept.
- out, output, WIDTH: signed actuator command.
- out_valid, output, 1: one-cycle pulse when out updates.
- sat_hi, output, 1: last out was clamped to OUT_MAX.
- sat_lo, output, 1: last out was clamped to OUT_MIN.

## Operation
**Accept**
- A sample is accepted on an edge where in_valid & in_ready.
- in_ready = 1 only in IDLE. in_valid outside IDLE is ignored; the bench holds it and it is taken later.

**Error**
- e = setpoint − meas, computed at WIDTH+1 bits, then saturated to the signed WIDTH range.

**States**
- IDLE → MUL0 on accept.
- MUL0 → MUL1 → MUL2 → UPD → IDLE, unconditionally.

**Multiply-accumulate**
- One signed WIDTH×WIDTH multiplier is time-shared.
- MUL0 computes k0·e, MUL1 computes k1·e1, MUL2 computes k2·e2.
- Each product is sign-extended into a 2·WIDTH+2-bit accumulator, cleared at accept. No intermediate overflow is possible.

**UPD**
- sum = (acc >>> FRAC) + sign-extended u_prev. The shift is floor, toward −∞.
- Auto mode: out = clamp(sum, OUT_MIN, OUT_MAX), with sat_hi/sat_lo set accordingly.
- Manual mode: out = clamp(man_value), with the same flags. The accumulator result is discarded.
- In both modes: u_prev ← out (anti-windup and bumpless transfer), then e2 ← e1, e1 ← e.

**Reset**
- reset has priority in every state and aborts any computation in flight.
- Next state is IDLE.
- out, u_prev, e1, e2, acc, sat_hi, sat_lo, out_valid all return to 0; in_ready returns to 1.

## Timing
- Accept on edge E0.
- State is MUL0 after E0, MUL1 after E1, MUL2 after E2, UPD after E3.
- out, sat flags and histories update on E4; out_valid = 1 for the cycle after E4 only.
- in_ready goes high after E4, so the earliest next accept is E5. Throughput is 1 sample per 5 cycles.
- out holds between updates.
- Gain, man_en or man_value changes after E0 have no effect on the current sample.
- A reset asserted on any edge En gives reset values in the cycle after En, and no out_valid for the aborted sample.

## Structure
- Package pid_pkg holds:
  - the state enum (IDLE, MUL0, MUL1, MUL2, UPD);
  - the ACC_W = 2·WIDTH+2 width function;
  - the saturate and clamp helper functions.
- Sub-module pid_mac contains the signed multiplier, the operand mux selected by state, and the accumulator with clear/enable.
- The top level holds the FSM, the error/history registers and the output stage.

## Test plan
- Legacy gains, default parameters: k0=3, k1=−2, k2=2, setpoint=200, meas=0 for three samples → out = 600, 800, 1400. out_valid on E4 of each sample. in_ready low for the 4 cycles after each accept.
- Clamp with OUT_MAX=1000, same stimulus → out = 600, 800, 1000 with sat_hi=1 on the third only. The fourth sample starts from u_prev=1000: out = clamp(1000+600−400+400) = 1000.
- Error saturation: setpoint=32767, meas=−32768, k0=1, k1=k2=0 → e=32767, out=32767. Then setpoint=−32768, meas=32767 → the −1-biased saturated error gives out = 32767 − 32768 = −1.
- Fixed point, FRAC=2, k0=3, k1=k2=0:
  - e=5 → out=3.
  - Reset, then e=−5 → out=−4 (floor).
- Manual and bumpless:
  - man_en=1, man_value=500 → out=500.
  - Then man_en=0, e=0 with zero history → out=500, with no jump.
- Reset mid-operation, plus ignored input:
  - reset asserted while in MUL1 → next cycle out=0, in_ready=1, no out_valid. A following sample with e=200 and legacy gains gives out=600.
  - in_valid held high during a busy period is not accepted until IDLE.

Source files
------------

// File: rtl/pid_pkg.sv
// Shared state encoding and 64-bit signed arithmetic helpers for the incremental PID controller.
// The helpers compute on 64-bit values, so WIDTH must be 30 or less.
package pid_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL0 = 3'd1,
    MUL1 = 3'd2,
    MUL2 = 3'd3,
    UPD  = 3'd4
  } state_t;

  localparam int WIDE_W = 64;

  function automatic int acc_w(input int width);
    return (32'sd2 * width) + 32'sd2;
  endfunction

  function automatic logic signed [WIDE_W-1:0] clamp(
    input logic signed [WIDE_W-1:0] v,
    input logic signed [WIDE_W-1:0] lo,
    input logic signed [WIDE_W-1:0] hi
  );
    logic signed [WIDE_W-1:0] r;
    if (v > hi) r = hi;
    else if (v < lo) r = lo;
    else r = v;
    return r;
  endfunction

  function automatic logic signed [WIDE_W-1:0] saturate(
    input logic signed [WIDE_W-1:0] v,
    input int                       width
  );
    logic signed [WIDE_W-1:0] hi;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    return clamp(v, -hi - 64'sd1, hi);
  endfunction

endpackage

// File: rtl/pid_mac.sv
// Time-shared signed multiplier with a state-selected operand mux and a clearable accumulator.
module pid_mac
  import pid_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ACC_W = acc_w(WIDTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  state_t                  state_i,
  input  logic                    clr_i,
  input  logic signed [WIDTH-1:0] k0_i,
  input  logic signed [WIDTH-1:0] k1_i,
  input  logic signed [WIDTH-1:0] k2_i,
  input  logic signed [WIDTH-1:0] e0_i,
  input  logic signed [WIDTH-1:0] e1_i,
  input  logic signed [WIDTH-1:0] e2_i,
  output logic signed [ACC_W-1:0] acc_o
);

  logic signed [WIDTH-1:0]   op_k_s;
  logic signed [WIDTH-1:0]   op_e_s;
  logic                      en_s;
  logic signed [2*WIDTH-1:0] prod_s;
  logic signed [ACC_W-1:0]   acc_q;
  logic signed [ACC_W-1:0]   acc_d;

  always_comb begin
    op_k_s = '0;
    op_e_s = '0;
    en_s   = 1'b0;
    case (state_i)
      MUL0: begin op_k_s = k0_i; op_e_s = e0_i; en_s = 1'b1; end
      MUL1: begin op_k_s = k1_i; op_e_s = e1_i; en_s = 1'b1; end
      MUL2: begin op_k_s = k2_i; op_e_s = e2_i; en_s = 1'b1; end
      default: begin op_k_s = '0; op_e_s = '0; en_s = 1'b0; end
    endcase
  end

  // Operands are sign-extended to full product width so the low 2*WIDTH bits are the signed product.
  assign prod_s = $signed({{WIDTH{op_k_s[WIDTH-1]}}, op_k_s}) *
                  $signed({{WIDTH{op_e_s[WIDTH-1]}}, op_e_s});

  always_comb begin
    if (clr_i) begin
      acc_d = '0;
    end else if (en_s) begin
      acc_d = acc_q + $signed({{(ACC_W-2*WIDTH){prod_s[2*WIDTH-1]}}, prod_s});
    end else begin
      acc_d = acc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) acc_q <= '0;
    else acc_q <= acc_d;
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/pid_incr_ctrl.sv
// Velocity-form PID: u[n] = u[n-1] + K0*e[n] + K1*e[n-1] + K2*e[n-2], one sample per five cycles,
// with output clamping, anti-windup via the clamped history and bumpless manual override.
module pid_incr_ctrl
  import pid_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int FRAC    = 0,
  parameter int OUT_MIN = -(32'sd2 ** (WIDTH - 1)),
  parameter int OUT_MAX = (32'sd2 ** (WIDTH - 1)) - 32'sd1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] setpoint,
  input  logic signed [WIDTH-1:0] meas,
  input  logic signed [WIDTH-1:0] k0,
  input  logic signed [WIDTH-1:0] k1,
  input  logic signed [WIDTH-1:0] k2,
  input  logic                    man_en,
  input  logic signed [WIDTH-1:0] man_value,
  output logic signed [WIDTH-1:0] out,
  output logic                    out_valid,
  output logic                    sat_hi,
  output logic                    sat_lo
);

  localparam int ACC_W = acc_w(WIDTH);
  localparam int EXT_W = WIDE_W - WIDTH;
  localparam logic signed [WIDE_W-1:0] LO_W = 64'(OUT_MIN);
  localparam logic signed [WIDE_W-1:0] HI_W = 64'(OUT_MAX);

  state_t                  state_q, state_d;
  logic signed [WIDTH-1:0] e_q, e_d, e1_q, e1_d, e2_q, e2_d;
  logic signed [WIDTH-1:0] k0_q, k0_d, k1_q, k1_d, k2_q, k2_d;
  logic signed [WIDTH-1:0] man_val_q, man_val_d, out_q, out_d;
  logic                    man_en_q, man_en_d, sat_hi_q, sat_hi_d, sat_lo_q, sat_lo_d;
  logic                    out_valid_q, out_valid_d;
  logic                    accept_s;
  logic signed [ACC_W-1:0] acc_s;
  logic signed [WIDE_W-1:0] sp_w_s, ms_w_s, err_w_s, acc_w_s, u_w_s, man_w_s;
  logic signed [WIDE_W-1:0] sum_s, cmd_s, res_s;
  logic                     unused_s;

  pid_mac #(.WIDTH(WIDTH), .ACC_W(ACC_W)) u_mac (
    .clk     (clk),
    .reset   (reset),
    .state_i (state_q),
    .clr_i   (accept_s),
    .k0_i    (k0_q),
    .k1_i    (k1_q),
    .k2_i    (k2_q),
    .e0_i    (e_q),
    .e1_i    (e1_q),
    .e2_i    (e2_q),
    .acc_o   (acc_s)
  );

  assign accept_s = in_valid && (state_q == IDLE);
  assign sp_w_s   = {{EXT_W{setpoint[WIDTH-1]}}, setpoint};
  assign ms_w_s   = {{EXT_W{meas[WIDTH-1]}}, meas};
  assign err_w_s  = saturate(sp_w_s - ms_w_s, WIDTH);
  assign acc_w_s  = {{(WIDE_W-ACC_W){acc_s[ACC_W-1]}}, acc_s};
  // out_q doubles as u[n-1]: the clamped value is what feeds back, which is the anti-windup.
  assign u_w_s    = {{EXT_W{out_q[WIDTH-1]}}, out_q};
  assign man_w_s  = {{EXT_W{man_val_q[WIDTH-1]}}, man_val_q};
  assign sum_s    = (acc_w_s >>> FRAC) + u_w_s;
  assign cmd_s    = man_en_q ? man_w_s : sum_s;
  assign res_s    = clamp(cmd_s, LO_W, HI_W);
  assign unused_s = ^{err_w_s[WIDE_W-1:WIDTH], res_s[WIDE_W-1:WIDTH]};

  always_comb begin
    state_d     = state_q;
    e_d         = e_q;
    e1_d        = e1_q;
    e2_d        = e2_q;
    k0_d        = k0_q;
    k1_d        = k1_q;
    k2_d        = k2_q;
    man_en_d    = man_en_q;
    man_val_d   = man_val_q;
    out_d       = out_q;
    sat_hi_d    = sat_hi_q;
    sat_lo_d    = sat_lo_q;
    out_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d   = MUL0;
          e_d       = err_w_s[WIDTH-1:0];
          k0_d      = k0;
          k1_d      = k1;
          k2_d      = k2;
          man_en_d  = man_en;
          man_val_d = man_value;
        end else begin
          state_d = IDLE;
        end
      end
      MUL0: state_d = MUL1;
      MUL1: state_d = MUL2;
      MUL2: state_d = UPD;
      UPD: begin
        state_d     = IDLE;
        out_d       = res_s[WIDTH-1:0];
        sat_hi_d    = (cmd_s > HI_W);
        sat_lo_d    = (cmd_s < LO_W);
        out_valid_d = 1'b1;
        e2_d        = e1_q;
        e1_d        = e_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      e_q         <= '0;
      e1_q        <= '0;
      e2_q        <= '0;
      k0_q        <= '0;
      k1_q        <= '0;
      k2_q        <= '0;
      man_en_q    <= 1'b0;
      man_val_q   <= '0;
      out_q       <= '0;
      sat_hi_q    <= 1'b0;
      sat_lo_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      e_q         <= e_d;
      e1_q        <= e1_d;
      e2_q        <= e2_d;
      k0_q        <= k0_d;
      k1_q        <= k1_d;
      k2_q        <= k2_d;
      man_en_q    <= man_en_d;
      man_val_q   <= man_val_d;
      out_q       <= out_d;
      sat_hi_q    <= sat_hi_d;
      sat_lo_q    <= sat_lo_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign sat_hi    = sat_hi_q;
  assign sat_lo    = sat_lo_q;

endmodule

// File: tb/tb_pid_incr_ctrl.sv
// Three controller instances (default, OUT_MAX=1000, FRAC=2) driven in lockstep, checked every cycle
// against a sample-level model and at each result against hand-computed values.
module tb_pid_incr_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, in_valid, man_en;
  logic signed [15:0] setpoint, meas, k0, k1, k2, man_value;
  logic               rdy [3];
  logic               ov  [3];
  logic               shi [3];
  logic               slo [3];
  logic signed [15:0] dout[3];

  int errors = 0;
  int checks = 0;

  localparam int     FR  [3] = '{0, 0, 2};
  localparam longint OMAX[3] = '{64'sd32767, 64'sd1000, 64'sd32767};
  localparam longint OMIN    = -64'sd32768;

  pid_incr_ctrl #(.WIDTH(16), .FRAC(0)) u_dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[0]),
    .setpoint(setpoint), .meas(meas), .k0(k0), .k1(k1), .k2(k2),
    .man_en(man_en), .man_value(man_value), .out(dout[0]), .out_valid(ov[0]),
    .sat_hi(shi[0]), .sat_lo(slo[0]));

  pid_incr_ctrl #(.WIDTH(16), .FRAC(0), .OUT_MAX(1000)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[1]),
    .setpoint(setpoint), .meas(meas), .k0(k0), .k1(k1), .k2(k2),
    .man_en(man_en), .man_value(man_value), .out(dout[1]), .out_valid(ov[1]),
    .sat_hi(shi[1]), .sat_lo(slo[1]));

  pid_incr_ctrl #(.WIDTH(16), .FRAC(2)) u_dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[2]),
    .setpoint(setpoint), .meas(meas), .k0(k0), .k1(k1), .k2(k2),
    .man_en(man_en), .man_value(man_value), .out(dout[2]), .out_valid(ov[2]),
    .sat_hi(shi[2]), .sat_lo(slo[2]));

  // Sample-level model: result computed at accept, published four edges later.
  bit     m_init = 1'b0;
  int     mbusy  = 0;
  bit     mov    = 1'b0;
  longint me1 = 0, me2 = 0, pe = 0;
  longint mout[3], pout[3];
  bit     mhi[3], mlo[3], phi[3], plo[3];

  function automatic longint lclamp(input longint v, input longint lo, input longint hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  initial begin
    for (int i = 0; i < 3; i++) begin
      mout[i] = 0; pout[i] = 0; mhi[i] = 1'b0; mlo[i] = 1'b0; phi[i] = 1'b0; plo[i] = 1'b0;
    end
    forever begin
      @(posedge clk);
      if (reset) begin
        mbusy = 0; mov = 1'b0; me1 = 0; me2 = 0; m_init = 1'b1;
        for (int i = 0; i < 3; i++) begin mout[i] = 0; mhi[i] = 1'b0; mlo[i] = 1'b0; end
      end else begin
        mov = 1'b0;
        if (mbusy == 0 && in_valid) begin
          longint e, v, s;
          e = lclamp(longint'(setpoint) - longint'(meas), -64'sd32768, 64'sd32767);
          for (int i = 0; i < 3; i++) begin
            v = longint'(k0) * e + longint'(k1) * me1 + longint'(k2) * me2;
            s = (v >>> FR[i]) + mout[i];
            if (man_en) s = longint'(man_value);
            pout[i] = lclamp(s, OMIN, OMAX[i]);
            phi[i]  = (s > OMAX[i]);
            plo[i]  = (s < OMIN);
          end
          pe = e;
          mbusy = 4;
        end else if (mbusy > 0) begin
          mbusy = mbusy - 1;
          if (mbusy == 0) begin
            for (int i = 0; i < 3; i++) begin mout[i] = pout[i]; mhi[i] = phi[i]; mlo[i] = plo[i]; end
            mov = 1'b1;
            me2 = me1;
            me1 = pe;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (m_init) begin
        for (int i = 0; i < 3; i++) begin
          checks++;
          if (longint'(dout[i]) !== mout[i] || ov[i] !== mov || rdy[i] !== (mbusy == 0) ||
              shi[i] !== mhi[i] || slo[i] !== mlo[i]) begin
            errors++;
            $display("FAIL model dut%0d t=%0t: out=%0d ov=%b rdy=%b hi=%b lo=%b, need out=%0d ov=%b rdy=%b hi=%b lo=%b",
                     i, $time, dout[i], ov[i], rdy[i], shi[i], slo[i],
                     mout[i], mov, (mbusy == 0), mhi[i], mlo[i]);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drive(input longint sp, input longint m, input longint g0, input longint g1,
                       input longint g2, input bit men, input longint mv);
    setpoint = 16'(sp); meas = 16'(m);
    k0 = 16'(g0); k1 = 16'(g1); k2 = 16'(g2);
    man_en = men; man_value = 16'(mv);
  endtask

  task automatic sample(input longint sp, input longint m, input longint g0, input longint g1,
                        input longint g2, input bit men, input longint mv,
                        input longint x0, input longint x1, input longint x2, input string name);
    int n;
    int lat;
    @(negedge clk);
    drive(sp, m, g0, g1, g2, men, mv);
    in_valid = 1'b1;
    n = 0;
    while (mbusy != 0 && n < 10) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    // Disturb latched inputs after accept; the current sample must not see this.
    drive(sp + 7, m - 3, 5, 5, 5, ~men, 1234);
    lat = 1;
    while (!ov[0] && lat < 8) begin @(negedge clk); lat++; end
    chk({name, " latency"}, lat, 5);
    chk({name, " out0"}, longint'(dout[0]), x0);
    chk({name, " out1"}, longint'(dout[1]), x1);
    chk({name, " out2"}, longint'(dout[2]), x2);
  endtask

  initial begin
    int pulses, first_c, second_c, low_rdy;
    longint v1, v2;
    reset = 1'b1; in_valid = 1'b0;
    drive(0, 0, 0, 0, 0, 1'b0, 0);
    do_reset();
    chk("reset out", longint'(dout[0]), 0);
    chk("reset in_ready", longint'(rdy[0]), 1);
    chk("reset out_valid", longint'(ov[0]), 0);

    sample(200, 0, 3, -2, 2, 1'b0, 0, 600, 600, 150, "leg1");
    chk("leg1 sat_hi1", longint'(shi[1]), 0);
    sample(200, 0, 3, -2, 2, 1'b0, 0, 800, 800, 200, "leg2");
    chk("leg2 sat_hi1", longint'(shi[1]), 0);
    sample(200, 0, 3, -2, 2, 1'b0, 0, 1400, 1000, 350, "leg3");
    chk("leg3 sat_hi1", longint'(shi[1]), 1);
    chk("leg3 sat_hi0", longint'(shi[0]), 0);
    sample(200, 0, 3, -2, 2, 1'b0, 0, 2000, 1000, 500, "leg4");
    chk("leg4 sat_hi1", longint'(shi[1]), 1);

    do_reset();
    sample(32767, -32768, 1, 0, 0, 1'b0, 0, 32767, 1000, 8191, "esat1");
    chk("esat1 sat_hi0", longint'(shi[0]), 0);
    sample(-32768, 32767, 1, 0, 0, 1'b0, 0, -1, -31768, -1, "esat2");

    do_reset();
    sample(5, 0, 3, 0, 0, 1'b0, 0, 15, 15, 3, "frac_pos");
    do_reset();
    sample(-5, 0, 3, 0, 0, 1'b0, 0, -15, -15, -4, "frac_neg");

    do_reset();
    sample(0, 0, 3, -2, 2, 1'b1, 500, 500, 500, 500, "manual");
    sample(0, 0, 3, -2, 2, 1'b0, 0, 500, 500, 500, "bumpless");
    sample(0, 0, 3, -2, 2, 1'b1, 2000, 2000, 1000, 2000, "man_clamp");
    chk("man_clamp sat_hi1", longint'(shi[1]), 1);

    do_reset();
    sample(-32768, 0, 2, 0, 0, 1'b0, 0, -32768, -32768, -16384, "satlo");
    chk("satlo sat_lo0", longint'(slo[0]), 1);
    chk("satlo sat_lo2", longint'(slo[2]), 0);

    // Abort a sample in MUL1.
    @(negedge clk);
    drive(200, 0, 3, -2, 2, 1'b0, 0);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("abort hold out", longint'(dout[0]), -32768);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort out", longint'(dout[0]), 0);
    chk("abort in_ready", longint'(rdy[0]), 1);
    chk("abort out_valid", longint'(ov[0]), 0);
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ov[0]) pulses++;
    end
    chk("abort no pulse", pulses, 0);
    sample(200, 0, 3, -2, 2, 1'b0, 0, 600, 600, 150, "post_rst");

    // in_valid held through a busy period: second accept only once idle again.
    do_reset();
    @(negedge clk);
    drive(200, 0, 3, -2, 2, 1'b0, 0);
    in_valid = 1'b1;
    pulses = 0; first_c = 0; second_c = 0; low_rdy = 0; v1 = 0; v2 = 0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (c == 6) in_valid = 1'b0;
      if (c <= 4 && !rdy[0]) low_rdy++;
      if (ov[0]) begin
        pulses++;
        if (pulses == 1) begin first_c = c; v1 = longint'(dout[0]); end
        if (pulses == 2) begin second_c = c; v2 = longint'(dout[0]); end
      end
    end
    chk("held busy cycles", low_rdy, 4);
    chk("held pulses", pulses, 2);
    chk("held first cycle", first_c, 5);
    chk("held second cycle", second_c, 10);
    chk("held first out", v1, 600);
    chk("held second out", v2, 800);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
